bcd_seg7_scan: RTL

BCD_SEG7_SCAN -- requirements
Module: bcd_seg7_scan

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_seg7_scan.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the BCD seven-segment scanner: segment patterns
// ({g,f,e,d,c,b,a}, logical 1 = lit) and the scan FSM state encoding.
package seg7_pkg;

  typedef enum logic [1:0] {
    s_IDLE     = 2'd0,
    s_DIGIT_ON = 2'd1,
    s_DEAD     = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble-to-segment decoder; non-decimal nibbles show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the standard seven-segment glyphs
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed BCD display driver: lights one digit at a time for SCAN_DIV
// cycles with DEAD_TIME all-off cycles between digits, leading-zero blanking.
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int DECIMAL_DIGITS = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_TIME      = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_DV,
  output logic [6:0]                    o_Segments,
  output logic [DECIMAL_DIGITS-1:0]     o_Digit_En,
  output logic                          o_Active
);

  localparam int BCD_W   = DECIMAL_DIGITS * 4;
  localparam int IDX_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > DEAD_TIME) ? SCAN_DIV : DEAD_TIME;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]          LIT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]          DEAD_LAST = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0]          CNT_ZERO  = CNT_W'(0);
  localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(DECIMAL_DIGITS - 1);
  localparam logic [IDX_W-1:0]          IDX_ZERO  = IDX_W'(0);
  localparam logic [DECIMAL_DIGITS-1:0] EN_ONE    = DECIMAL_DIGITS'(1);
  localparam logic [DECIMAL_DIGITS-1:0] EN_POL    =
    (SEG_ACTIVE_LOW != 0) ? {DECIMAL_DIGITS{1'b1}} : {DECIMAL_DIGITS{1'b0}};
  localparam logic [6:0]                SEG_POL   =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t                   state_r, state_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;
  logic [BCD_W-1:0]         bcd_r, bcd_s;
  logic [3:0]               nib_s;
  logic                     blank_s;
  logic [6:0]               seg_dec_s;
  logic [6:0]               seg_lit_s;
  logic [DECIMAL_DIGITS-1:0] en_lit_s;
  logic [6:0]               seg_r;
  logic [DECIMAL_DIGITS-1:0] en_r;
  logic                     active_r;

  // Next-state view; outputs are registered from it so they line up with the state
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    bcd_s   = i_DV ? i_BCD : bcd_r;
    case (state_r)
      s_IDLE: begin
        if (i_DV) begin
          state_s = s_DIGIT_ON;
          idx_s   = IDX_ZERO;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = s_IDLE;
        end
      end
      s_DIGIT_ON: begin
        if (cnt_r == LIT_LAST) begin
          state_s = s_DEAD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      s_DEAD: begin
        if (cnt_r == DEAD_LAST) begin
          state_s = s_DIGIT_ON;
          cnt_s   = CNT_ZERO;
          idx_s   = (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IDX_W'(1);
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = s_IDLE;
        idx_s   = IDX_ZERO;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Digit mux and blanking: a digit is blank when it and everything above it is zero
  always_comb begin
    nib_s     = bcd_s[{idx_s, 2'b00} +: 4];
    blank_s   = (idx_s != IDX_ZERO) && ((bcd_s >> {idx_s, 2'b00}) == BCD_W'(0));
    seg_lit_s = blank_s ? SEG_BLANK : seg_dec_s;
    en_lit_s  = EN_ONE << idx_s;
  end

  bcd_to_seg7 u_dec (
    .bcd (nib_s),
    .seg (seg_dec_s)
  );

  // Scan FSM state plus pin-polarity output registers
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r  <= s_IDLE;
      idx_r    <= IDX_ZERO;
      cnt_r    <= CNT_ZERO;
      bcd_r    <= BCD_W'(0);
      active_r <= 1'b0;
      seg_r    <= SEG_POL;
      en_r     <= EN_POL;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      cnt_r    <= cnt_s;
      bcd_r    <= bcd_s;
      active_r <= active_r | i_DV;
      if (state_s == s_DIGIT_ON) begin
        seg_r <= seg_lit_s ^ SEG_POL;
        en_r  <= en_lit_s ^ EN_POL;
      end else begin
        seg_r <= SEG_BLANK ^ SEG_POL;
        en_r  <= EN_POL;
      end
    end
  end

  assign o_Segments = seg_r;
  assign o_Digit_En = en_r;
  assign o_Active   = active_r;

endmodule
